// File: rtl/f_pc_ctrl_if.sv
// Fetch-stage bus between the PC sequencer and the rest of the core:
// D-stage next-PC controls, instruction-memory port and F/D register outputs.
interface f_pc_ctrl_if;
   logic        i_stall;
   logic [2:0]  i_npcOp;
   logic        i_jumpEn_of_B;
   logic [31:0] i_jr_target;
   logic [31:0] i_imem_rdata;
   logic [31:0] o_imem_addr;
   logic [31:0] o_F_pc;
   logic [31:0] o_D_pc;
   logic [31:0] o_D_instr;
   logic        o_D_valid;
   logic        o_addr_err;

   // master: the fetch sequencer itself; slave: the core / memory side
   modport master (
      input  i_stall, i_npcOp, i_jumpEn_of_B, i_jr_target, i_imem_rdata,
      output o_imem_addr, o_F_pc, o_D_pc, o_D_instr, o_D_valid, o_addr_err
   );
   modport slave (
      output i_stall, i_npcOp, i_jumpEn_of_B, i_jr_target, i_imem_rdata,
      input  o_imem_addr, o_F_pc, o_D_pc, o_D_instr, o_D_valid, o_addr_err
   );
endinterface

// File: rtl/f_pc_ctrl.sv
// Fetch-stage PC sequencer and F/D pipeline register for the 5-stage MIPS core.
// Redirects decoded in D take effect on the next edge; the delay slot is never squashed.
module f_pc_ctrl #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter logic [31:0] PC_LO    = 32'h0000_3000,
   parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   f_pc_ctrl_if.master   bus
);

   typedef enum logic [2:0] {
      NPC_PC4    = 3'd0,
      NPC_BRANCH = 3'd1,
      NPC_J      = 3'd2,
      NPC_JR     = 3'd3
   } npc_op_e;

   logic [31:0] pc;
   logic [31:0] d_pc;
   logic [31:0] d_instr;
   logic        d_valid;
   logic        addr_err;

   logic [31:0] pc4_d;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic [31:0] next_pc;
   logic        next_illegal;

   // Targets come only from D-stage registers, so no input reaches an output combinationally.
   always_comb begin
      pc4_d     = d_pc + 32'd4;
      br_target = pc4_d + {{14{d_instr[15]}}, d_instr[15:0], 2'b00};
      j_target  = {pc4_d[31:28], d_instr[25:0], 2'b00};

      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      next_pc = pc + 32'd4;
      if (d_valid) begin
         case (bus.i_npcOp)
            NPC_BRANCH: if (bus.i_jumpEn_of_B) next_pc = br_target;
            NPC_J:      next_pc = j_target;
            NPC_JR:     next_pc = bus.i_jr_target;
            default:    next_pc = pc + 32'd4;
         endcase
      end

      next_illegal = (next_pc < PC_LO) || (next_pc > PC_HI) || (next_pc[1:0] != 2'b00);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         pc       <= PC_RESET;
         d_pc     <= PC_RESET;
         d_instr  <= 32'd0;
         d_valid  <= 1'b0;
         addr_err <= 1'b0;
      end else if (!bus.i_stall) begin
         pc      <= next_pc;
         d_pc    <= pc;
         d_instr <= bus.i_imem_rdata;
         d_valid <= 1'b1;
         // Sticky: the illegal PC is still loaded and fetched; handling is downstream.
         if (next_illegal) addr_err <= 1'b1;
      end
   end

   assign bus.o_imem_addr = pc;
   assign bus.o_F_pc      = pc;
   assign bus.o_D_pc      = d_pc;
   assign bus.o_D_instr   = d_instr;
   assign bus.o_D_valid   = d_valid;
   assign bus.o_addr_err  = addr_err;

endmodule

// File: tb/tb_f_pc_ctrl.sv
// Self-checking bench for f_pc_ctrl: a behavioural model pushes the expected
// register state per cycle into a scoreboard queue, popped and compared after each edge.
module tb_f_pc_ctrl;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] d_pc;
      logic [31:0] d_instr;
      logic        d_valid;
      logic        err;
   } exp_t;

   logic clk;
   logic rst_n;
   logic alt_j;
   int   n_vec;
   int   n_err;

   exp_t sb_q[$];
   exp_t m;

   f_pc_ctrl_if bus ();

   f_pc_ctrl dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: a few fixed words, everything else a harmless filler.
   function automatic logic [31:0] imem_word(input logic [31:0] a, input logic alt);
      case (a)
         32'h0000_3010: return 32'h1000_0003;                    // beq, imm16 = 3
         32'h0000_3040: return alt ? 32'h0800_0C10 : 32'h1000_FFFE; // j 0xC10 / beq imm16 = -2
         default:       return {16'h2400, a[15:0]};
      endcase
   endfunction

   always_comb bus.i_imem_rdata = imem_word(bus.o_imem_addr, alt_j);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Reference next state, written in signed/behavioural form.
   function automatic exp_t model_next(input exp_t s, input logic rn, input logic st,
                                       input logic [2:0] op, input logic jen,
                                       input logic [31:0] jr);
      exp_t n;
      logic signed [31:0] off;
      logic [31:0] tgt;
      logic redirect;
      n = s;
      if (!rn) begin
         n.pc = 32'h3000; n.d_pc = 32'h3000; n.d_instr = '0; n.d_valid = 1'b0; n.err = 1'b0;
      end else if (!st) begin
         off = $signed(s.d_instr[15:0]);
         off = off * 4;
         redirect = 1'b0;
         tgt = s.pc + 32'd4;
         if (s.d_valid && op == 3'd1 && jen) begin redirect = 1'b1; tgt = s.d_pc + 32'd4 + off; end
         if (s.d_valid && op == 3'd2) begin
            redirect = 1'b1;
            tgt = ((s.d_pc + 32'd4) & 32'hF000_0000) | ({6'd0, s.d_instr[25:0]} * 4);
         end
         if (s.d_valid && op == 3'd3) begin redirect = 1'b1; tgt = jr; end
         n.d_pc    = s.pc;
         n.d_instr = imem_word(s.pc, alt_j);
         n.d_valid = 1'b1;
         n.pc      = redirect ? tgt : s.pc + 32'd4;
         if (n.pc < 32'h3000 || n.pc > 32'h6FFC || n.pc[1:0] != 2'b00) n.err = 1'b1;
      end
      return n;
   endfunction

   task automatic step(input logic rn, input logic st, input logic [2:0] op,
                       input logic jen, input logic [31:0] jr);
      exp_t e;
      rst_n             = rn;
      bus.i_stall       = st;
      bus.i_npcOp       = op;
      bus.i_jumpEn_of_B = jen;
      bus.i_jr_target   = jr;
      sb_q.push_back(model_next(m, rn, st, op, jen, jr));
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("pc",      bus.o_imem_addr, e.pc);
      check("f_pc",    bus.o_F_pc,      e.pc);
      check("d_pc",    bus.o_D_pc,      e.d_pc);
      check("d_instr", bus.o_D_instr,   e.d_instr);
      check("d_valid", {31'd0, bus.o_D_valid},  {31'd0, e.d_valid});
      check("err",     {31'd0, bus.o_addr_err}, {31'd0, e.err});
      m = e;
   endtask

   // Sequential fetch until D holds the wanted PC, bounded.
   task automatic run_to_d(input logic [31:0] target);
      for (int i = 0; i < 64 && bus.o_D_pc !== target; i++) step(1, 0, 3'd0, 0, '0);
      check("reach_d", bus.o_D_pc, target);
   endtask

   task automatic jump_to(input logic [31:0] target);
      step(1, 0, 3'd3, 0, target);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0; n_err = 0; alt_j = 1'b0; m = '0;
      rst_n = 1'b0; bus.i_stall = 1'b0; bus.i_npcOp = '0;
      bus.i_jumpEn_of_B = 1'b0; bus.i_jr_target = '0;

      // Reset and sequential fetch
      step(0, 0, 3'd0, 0, '0);
      step(0, 0, 3'd0, 0, '0);
      check("rst_pc",    bus.o_imem_addr, 32'h3000);
      check("rst_valid", {31'd0, bus.o_D_valid}, 32'd0);
      step(1, 0, 3'd0, 0, '0);
      check("seq_pc1",   bus.o_imem_addr, 32'h3004);
      check("seq_dpc1",  bus.o_D_pc, 32'h3000);
      check("seq_valid", {31'd0, bus.o_D_valid}, 32'd1);
      step(1, 0, 3'd0, 0, '0);
      check("seq_pc2",   bus.o_imem_addr, 32'h3008);

      // Taken beq at 0x3010, delay slot 0x3014, then target 0x3020
      run_to_d(32'h3010);
      step(1, 0, 3'd1, 1, '0);
      check("beq_t_pc",   bus.o_imem_addr, 32'h3020);
      check("beq_t_slot", bus.o_D_pc, 32'h3014);
      step(1, 0, 3'd0, 0, '0);
      check("beq_t_dtgt", bus.o_D_pc, 32'h3020);

      // Not-taken beq at 0x3010
      jump_to(32'h3010);
      run_to_d(32'h3010);
      step(1, 0, 3'd1, 0, '0);
      check("beq_nt_pc", bus.o_imem_addr, 32'h3018);

      // Backward branch at 0x3040
      jump_to(32'h3040);
      run_to_d(32'h3040);
      step(1, 0, 3'd1, 1, '0);
      check("beq_back", bus.o_imem_addr, 32'h303C);

      // j at 0x3040
      alt_j = 1'b1;
      jump_to(32'h3040);
      run_to_d(32'h3040);
      step(1, 0, 3'd2, 0, '0);
      check("j_pc", bus.o_imem_addr, 32'h3040);
      alt_j = 1'b0;
      step(1, 0, 3'd0, 0, '0);

      // jr under a 3-cycle stall
      begin
         exp_t hold;
         hold = m;
         for (int i = 0; i < 3; i++) begin
            step(1, 1, 3'd3, 0, 32'h3100);
            check("stall_pc",    bus.o_imem_addr, hold.pc);
            check("stall_dpc",   bus.o_D_pc, hold.d_pc);
            check("stall_instr", bus.o_D_instr, hold.d_instr);
         end
      end
      step(1, 0, 3'd3, 0, 32'h3100);
      check("jr_pc", bus.o_imem_addr, 32'h3100);

      // Address error: misaligned, sticky through normal fetch, cleared by reset
      jump_to(32'h3102);
      check("err_mis_pc", bus.o_imem_addr, 32'h3102);
      check("err_mis",    {31'd0, bus.o_addr_err}, 32'd1);
      for (int i = 0; i < 3; i++) step(1, 0, 3'd0, 0, '0);
      check("err_sticky", {31'd0, bus.o_addr_err}, 32'd1);
      step(0, 0, 3'd0, 0, '0);
      check("err_clr", {31'd0, bus.o_addr_err}, 32'd0);
      step(1, 0, 3'd0, 0, '0);
      jump_to(32'h6FFC);
      check("err_hi_ok", {31'd0, bus.o_addr_err}, 32'd0);
      jump_to(32'h7000);
      check("err_above", {31'd0, bus.o_addr_err}, 32'd1);
      step(0, 0, 3'd0, 0, '0);
      step(1, 0, 3'd0, 0, '0);
      jump_to(32'h2FFC);
      check("err_below", {31'd0, bus.o_addr_err}, 32'd1);

      // Reset on the edge a taken branch sits in D
      step(0, 0, 3'd0, 0, '0);
      step(1, 0, 3'd0, 0, '0);
      run_to_d(32'h3010);
      step(0, 0, 3'd1, 1, '0);
      check("rst_redir_pc",    bus.o_imem_addr, 32'h3000);
      check("rst_redir_valid", {31'd0, bus.o_D_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 3'd0, 0, '0);
         check("rst_no_tgt", {31'd0, (bus.o_imem_addr == 32'h3020)}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/f_pc_ctrl.md
Name: f_pc_ctrl

Overview:
- Fetch-stage PC sequencer and F/D pipeline register for the 5-stage MIPS core.
- Holds the PC and drives the instruction-memory address.
- Captures fetched instructions into the D stage.
- Applies next-PC redirects decoded in D: branch decision from the D-stage comparator output `o_jumpEn_of_B`, plus j/jal/jr.
- Uses MIPS delay-slot semantics, so there is no flush.

Parameters:
- PC_RESET, 32'h0000_3000: PC value after reset.
- PC_LO, 32'h0000_3000: lowest legal fetch address.
- PC_HI, 32'h0000_6FFC: highest legal fetch address.

Ports:
- i_clk  in  1  system clock; all state updates on rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_stall  in  1  hazard-unit stall; freezes PC and F/D register.
- i_npcOp  in  3  D-stage next-PC select: 0 PC4, 1 BRANCH, 2 J, 3 JR; other codes are treated as PC4.
- i_jumpEn_of_B  in  1  branch-taken flag from the D-stage comparator; used only when i_npcOp==BRANCH.
- i_jr_target  in  32  forwarded rs value for jr/jalr.
- i_imem_rdata  in  32  instruction word at o_imem_addr (combinational read).
- o_imem_addr  out  32  current F-stage PC.
- o_F_pc  out  32  same as o_imem_addr (for exception/debug tap).
- o_D_pc  out  32  PC of the instruction held in D.
- o_D_instr  out  32  instruction held in D.
- o_D_valid  out  1  D holds a real fetched instruction.
- o_addr_err  out  1  sticky flag: an illegal fetch address was loaded into PC.

Behaviour:
- Reset values (i_reset_n==0 at a clock edge):
  - PC = PC_RESET.
  - o_D_pc = PC_RESET; o_D_instr = 0; o_D_valid = 0; o_addr_err = 0.
  - Reset wins over every other input.
- Targets, computed from D-stage registers (o_D_pc, o_D_instr) only:
  - pc4D = o_D_pc + 4.
  - BRANCH target = pc4D + (sign-extend(o_D_instr[15:0]) << 2). All arithmetic is 32-bit with wrap-around; no overflow trap.
  - J target = {pc4D[31:28], o_D_instr[25:0], 2'b00}.
  - JR target = i_jr_target, used unmodified.
- Next-PC selection, in priority order:
  1. Reset.
  2. i_stall=1: PC holds.
  3. o_D_valid=1 and the D instruction redirects, i.e. npcOp==J, npcOp==JR, or (npcOp==BRANCH and i_jumpEn_of_B==1): PC = target.
  4. Otherwise PC = PC + 4. This includes BRANCH not taken and o_D_valid=0.
- Delay slot:
  - When a redirect is applied, the instruction currently in F (at D_pc+4) still advances into D normally and is executed.
  - No instruction is ever squashed.
- F/D register:
  - Not stalled: o_D_pc = PC, o_D_instr = i_imem_rdata, o_D_valid = 1, all on the same edge the PC updates.
  - Stalled: all three hold. A redirect decision present during a stall is not applied; it is re-evaluated with fresh operands after the stall releases.
- Latency:
  - A redirect decoded in D takes effect on the next edge: new PC visible one cycle after the branch is in D.
  - The target instruction reaches D two cycles after the branch entered D.
- Address check:
  - On any PC load (not a hold), o_addr_err is set to 1 if the next PC is < PC_LO, > PC_HI, or has bits [1:0] != 0.
  - The flag stays 1 until reset.
  - The illegal value is still loaded and fetched. Handling is downstream.
- Reset mid-operation: any in-flight redirect is discarded; the next fetch is PC_RESET.
- All outputs are registers or direct copies of registers; there is no combinational path from inputs to outputs.

Test Plan:
- Reset and sequential fetch: hold i_reset_n=0 for 2 cycles, then release with npcOp=0, no stall.
  - During reset: o_imem_addr=0x3000, o_D_valid=0.
  - After release, o_imem_addr steps 0x3004, 0x3008, ….
  - One cycle after release: o_D_pc=0x3000, o_D_valid=1.
- Taken beq:
  - Setup: D holds pc 0x3010, instr imm16=0x0003; npcOp=1, jumpEn=1.
  - Required: next PC = 0x3020. The delay slot 0x3014 enters D, then 0x3020 follows. No other address is fetched between them.
  - Repeat with jumpEn=0: next PC = 0x3018.
- Backward branch and j:
  - Branch with imm16=0xFFFE at D pc 0x3040: target 0x303C.
  - j with instr[25:0]=0x0000C10 at D pc 0x3040: target 0x00003040.
- jr with stall:
  - Setup: i_jr_target=0x3100 arrives while i_stall=1 for 3 cycles.
  - During the stall: PC, o_D_pc and o_D_instr are unchanged.
  - First unstalled edge: PC = 0x3100.
- Address error:
  - jr to 0x3102 → o_addr_err=1 after the edge, and PC=0x3102.
  - Flag stays 1 through subsequent normal fetches; cleared only by reset.
  - jr to 0x7000 also sets the flag.
- Reset during redirect:
  - Setup: assert i_reset_n=0 on the same edge a taken branch is in D.
  - Required: PC=0x3000, o_D_valid=0, and the target is never fetched.
